// File: rtl/axi_burst_sram_pkg.sv
// axi_burst_sram_pkg: shared constants for the burst SRAM slave.
// Holds the write/read FSM state encodings, the AXI response codes and the
// fixed AXI field widths used by the interface and the top level.
package axi_burst_sram_pkg;

  // Fixed AXI field widths
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_LEN_W  = 8;
  localparam int AXI_ID_W   = 4;   // default transaction ID width

  // Response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write FSM states
  typedef logic [1:0] w_state_t;
  localparam w_state_t W_IDLE = 2'd0;
  localparam w_state_t W_DATA = 2'd1;
  localparam w_state_t W_RESP = 2'd2;

  // Read FSM states
  typedef logic [0:0] r_state_t;
  localparam r_state_t R_IDLE = 1'b0;
  localparam r_state_t R_DATA = 1'b1;

endpackage

// File: rtl/axi_burst_sram_if.sv
// axi_burst_sram_if: AXI4 burst bus (AW, W, B, AR, R channels).
// Parameters: DATA_WIDTH (beat width), ID_WIDTH (transaction ID width).
// Modports: slave (memory side), master (initiator side).
interface axi_burst_sram_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = axi_burst_sram_pkg::AXI_ID_W
) ();

  // AW channel
  logic                                    awvalid;
  logic                                    awready;
  logic [ID_WIDTH-1:0]                     awid;
  logic [axi_burst_sram_pkg::AXI_ADDR_W-1:0] awaddr;
  logic [axi_burst_sram_pkg::AXI_LEN_W-1:0]  awlen;
  // W channel
  logic                                    wvalid;
  logic                                    wready;
  logic [DATA_WIDTH-1:0]                   wdata;
  logic [DATA_WIDTH/8-1:0]                 wstrb;
  logic                                    wlast;
  // B channel
  logic                                    bvalid;
  logic                                    bready;
  logic [ID_WIDTH-1:0]                     bid;
  logic [1:0]                              bresp;
  // AR channel
  logic                                    arvalid;
  logic                                    arready;
  logic [ID_WIDTH-1:0]                     arid;
  logic [axi_burst_sram_pkg::AXI_ADDR_W-1:0] araddr;
  logic [axi_burst_sram_pkg::AXI_LEN_W-1:0]  arlen;
  // R channel
  logic                                    rvalid;
  logic                                    rready;
  logic [ID_WIDTH-1:0]                     rid;
  logic [1:0]                              rresp;
  logic [DATA_WIDTH-1:0]                   rdata;
  logic                                    rlast;

  modport slave (
    input  awvalid, awid, awaddr, awlen,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, arid, araddr, arlen,
    output arready,
    output rvalid, rid, rresp, rdata, rlast,
    input  rready
  );

  modport master (
    output awvalid, awid, awaddr, awlen,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, arid, araddr, arlen,
    input  arready,
    input  rvalid, rid, rresp, rdata, rlast,
    output rready
  );

endinterface

// File: rtl/axi_burst_sram_mem.sv
// axi_burst_sram_mem: storage array with one byte-masked write port and one
// synchronous read port. Read and write share a clock edge, so a same-word
// read and write in one cycle returns the old contents.
// Ports: clk, rst_n (clears only the read register, never the array),
//        we/waddr/wdata/wstrb (write port), re/raddr/rdata (read port).
module axi_burst_sram_mem #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [DATA_WIDTH/8-1:0]  wstrb,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read register holds its value while re is low (R-channel stall).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_burst_sram.sv
// axi_burst_sram: AXI4 INCR-burst slave backed by an on-chip SRAM.
// Independent write (W_IDLE/W_DATA/W_RESP) and read (R_IDLE/R_DATA) FSMs.
// Ports: clock (rising edge), reset (async, active-low),
//        io_slave (axi_burst_sram_if.slave: AW, W, B, AR, R channels).
// Optional feature: define AXI_BURST_SRAM_RANGE_CHECK_EN to answer bursts
// starting at or beyond DEPTH*DATA_WIDTH/8 with SLVERR (writes dropped,
// reads return zero). Without it, addresses wrap modulo DEPTH.
module axi_burst_sram
  import axi_burst_sram_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1024,
  parameter int ID_WIDTH   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  axi_burst_sram_if.slave      io_slave
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  logic                 aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [IDX_W-1:0]     aw_idx, ar_idx;
  logic                 aw_err, ar_err;

  w_state_t             w_state;
  logic [ID_WIDTH-1:0]  w_id;
  logic [IDX_W-1:0]     w_idx;
  logic [AXI_LEN_W-1:0] w_len, w_cnt;
  logic                 w_err;

  r_state_t             r_state;
  logic [ID_WIDTH-1:0]  r_id;
  logic [IDX_W-1:0]     r_idx;
  logic [AXI_LEN_W-1:0] r_len, r_cnt;
  logic                 r_err;
  logic                 r_last;

  logic                 mem_we, mem_re;
  logic [IDX_W-1:0]     mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Byte offset bits and wlast carry no information for this slave.
  logic unused_bits;
  assign unused_bits = ^{io_slave.awaddr, io_slave.araddr, io_slave.wlast};

  // Word index: drop the byte offset, keep log2(DEPTH) bits (wraps modulo DEPTH).
  assign aw_idx = io_slave.awaddr[OFF_W +: IDX_W];
  assign ar_idx = io_slave.araddr[OFF_W +: IDX_W];

`ifdef AXI_BURST_SRAM_RANGE_CHECK_EN
  localparam logic [AXI_ADDR_W:0] ADDR_LIMIT = (AXI_ADDR_W+1)'(DEPTH) * (AXI_ADDR_W+1)'(STRB_W);
  assign aw_err = {1'b0, io_slave.awaddr} >= ADDR_LIMIT;
  assign ar_err = {1'b0, io_slave.araddr} >= ADDR_LIMIT;
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  assign aw_hs = io_slave.awvalid && io_slave.awready;
  assign w_hs  = io_slave.wvalid  && io_slave.wready;
  assign b_hs  = io_slave.bvalid  && io_slave.bready;
  assign ar_hs = io_slave.arvalid && io_slave.arready;
  assign r_hs  = io_slave.rvalid  && io_slave.rready;

  // Write FSM: beat count alone ends the burst.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (aw_hs) begin
          w_id    <= io_slave.awid;
          w_idx   <= aw_idx;
          w_len   <= io_slave.awlen;
          w_cnt   <= '0;
          w_err   <= aw_err;
          w_state <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          w_idx <= w_idx + IDX_W'(1);
          w_cnt <= w_cnt + AXI_LEN_W'(1);
          if (w_cnt == w_len) w_state <= W_RESP;
        end
        W_RESP: if (b_hs) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign io_slave.awready = (w_state == W_IDLE);
  assign io_slave.wready  = (w_state == W_DATA);
  assign io_slave.bvalid  = (w_state == W_RESP);
  assign io_slave.bid     = w_id;
  assign io_slave.bresp   = w_err ? RESP_SLVERR : RESP_OKAY;

  // Read FSM
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else if (r_state == R_IDLE) begin
      if (ar_hs) begin
        r_id    <= io_slave.arid;
        r_idx   <= ar_idx;
        r_len   <= io_slave.arlen;
        r_cnt   <= '0;
        r_err   <= ar_err;
        r_state <= R_DATA;
      end
    end else if (r_hs) begin
      r_idx <= r_idx + IDX_W'(1);
      r_cnt <= r_cnt + AXI_LEN_W'(1);
      if (r_last) r_state <= R_IDLE;
    end
  end

  assign r_last = (r_state == R_DATA) && (r_cnt == r_len);

  // The read port fetches one word ahead: the first beat on the AR handshake,
  // each following beat on the R handshake. Stalls leave rdata registered.
  assign mem_re    = ar_hs || (r_hs && !r_last);
  assign mem_raddr = ar_hs ? ar_idx : r_idx + IDX_W'(1);
  assign mem_we    = w_hs && !w_err;

  assign io_slave.arready = (r_state == R_IDLE);
  assign io_slave.rvalid  = (r_state == R_DATA);
  assign io_slave.rlast   = r_last;
  assign io_slave.rid     = r_id;
  assign io_slave.rresp   = r_err ? RESP_SLVERR : RESP_OKAY;
  assign io_slave.rdata   = r_err ? '0 : mem_rdata;

  axi_burst_sram_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clock),
    .rst_n (reset),
    .we    (mem_we),
    .waddr (w_idx),
    .wdata (io_slave.wdata),
    .wstrb (io_slave.wstrb),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_axi_burst_sram.sv
// tb_axi_burst_sram: randomized bench for axi_burst_sram with a word-array
// reference model of the memory. Directed bursts cover the basic write/read,
// strobe merge, index wrap and mid-burst reset; random bursts follow.
module tb_axi_burst_sram;

  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int BOUND = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_burst_sram_if #(.DATA_WIDTH(DW), .ID_WIDTH(4)) bus ();

  axi_burst_sram #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ID_WIDTH(4)) dut (
    .clock    (clk),
    .reset    (rst_n),
    .io_slave (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0]   ref_mem [DEPTH];
  logic [DW-1:0]   wbuf    [256];
  logic [DW/8-1:0] sbuf    [256];
  logic [DW-1:0]   rcap    [256];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [DW/8-1:0] strb);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < DW/8; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic bit addr_err(input logic [31:0] a);
`ifdef AXI_BURST_SRAM_RANGE_CHECK_EN
    return a >= 32'(DEPTH * (DW/8));
`else
    return (a != a);
`endif
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a / (DW/8)) % DEPTH);
  endfunction

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len, input bit gaps);
    int n, idx;
    bit err;
    err = addr_err(addr);
    idx = word_of(addr);
    bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len);
    n = 0;
    while (!bus.awready && n < BOUND) begin @(negedge clk); n++; end
    check("aw_wait", 64'(n < BOUND), 64'd1);
    @(negedge clk);
    bus.awvalid = 1'b0;
    check("wready_lat", 64'(bus.wready), 64'd1);
    for (int i = 0; i <= len; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.wvalid = 1'b0;
        @(negedge clk);
        check("wready_gap", 64'(bus.wready), 64'd1);
      end
      bus.wvalid = 1'b1; bus.wdata = wbuf[i]; bus.wstrb = sbuf[i];
      bus.wlast  = gaps ? 1'($urandom_range(0, 1)) : (i == len);
      @(negedge clk);
      if (!err) ref_mem[idx] = merge(ref_mem[idx], wbuf[i], sbuf[i]);
      idx = (idx + 1) % DEPTH;
      if (i < len) check("bvalid_early", 64'(bus.bvalid), 64'd0);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check("bvalid_lat", 64'(bus.bvalid), 64'd1);
    check("wready_off", 64'(bus.wready), 64'd0);
    check("bid", 64'(bus.bid), 64'(id));
    check("bresp", 64'(bus.bresp), err ? 64'd2 : 64'd0);
    n = $urandom_range(0, 2);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("bvalid_hold", 64'(bus.bvalid), 64'd1);
    end
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("bvalid_done", 64'(bus.bvalid), 64'd0);
    check("awready_back", 64'(bus.awready), 64'd1);
  endtask

  // mode 0: random rready, mode 1: rready toggles 1/0
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len, input int mode);
    int n, idx, beat;
    bit err, rr, ph;
    logic [DW-1:0] exp;
    err = addr_err(addr);
    idx = word_of(addr);
    bus.arvalid = 1'b1; bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len);
    n = 0;
    while (!bus.arready && n < BOUND) begin @(negedge clk); n++; end
    check("ar_wait", 64'(n < BOUND), 64'd1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("rvalid_lat", 64'(bus.rvalid), 64'd1);
    beat = 0; n = 0; ph = 1'b1;
    while (beat <= len && n < BOUND) begin
      exp = err ? '0 : ref_mem[(idx + beat) % DEPTH];
      rcap[beat] = bus.rdata;
      check("rvalid", 64'(bus.rvalid), 64'd1);
      check("rdata", bus.rdata, exp);
      check("rlast", 64'(bus.rlast), 64'(beat == len));
      check("rid", 64'(bus.rid), 64'(id));
      check("rresp", 64'(bus.rresp), err ? 64'd2 : 64'd0);
      rr = (mode == 1) ? ph : 1'($urandom_range(0, 1));
      ph = !ph;
      bus.rready = rr;
      @(negedge clk);
      if (rr) beat++;
      n++;
    end
    bus.rready = 1'b0;
    check("r_wait", 64'(n < BOUND), 64'd1);
    check("rvalid_done", 64'(bus.rvalid), 64'd0);
    check("arready_back", 64'(bus.arready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, idx;
    logic [31:0] addr;
    bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
    bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.rready = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_awready", 64'(bus.awready), 64'd1);
    check("rst_arready", 64'(bus.arready), 64'd1);
    check("rst_wready", 64'(bus.wready), 64'd0);
    check("rst_bvalid", 64'(bus.bvalid), 64'd0);
    check("rst_rvalid", 64'(bus.rvalid), 64'd0);
    check("rst_rlast", 64'(bus.rlast), 64'd0);
    check("rst_bid", 64'(bus.bid), 64'd0);
    check("rst_rid", 64'(bus.rid), 64'd0);
    check("rst_bresp", 64'(bus.bresp), 64'd0);
    check("rst_rresp", 64'(bus.rresp), 64'd0);
    check("rst_rdata", bus.rdata, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill whole memory so the model is fully defined
    for (int i = 0; i < DEPTH; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
    axi_write(4'd0, 32'h0, DEPTH - 1, 1'b0);

    // Basic 4-beat write then toggled-rready read
    for (int i = 0; i < 4; i++) begin wbuf[i] = 64'(8'h11 * (i + 1)); sbuf[i] = 8'hFF; end
    axi_write(4'd5, 32'h0, 3, 1'b0);
    axi_read(4'd9, 32'h0, 3, 1);
    check("read_beat4", rcap[3], 64'h44);

    // Strobe merge
    wbuf[0] = 64'h1122334455667788; sbuf[0] = 8'hFF;
    axi_write(4'd1, 32'h28, 0, 1'b0);
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF; sbuf[0] = 8'h0F;
    axi_write(4'd2, 32'h28, 0, 1'b0);
    axi_read(4'd3, 32'h28, 0, 0);
    check("strb_merge", rcap[0], 64'h11223344FFFFFFFF);

    // Wrap at DEPTH
    for (int i = 0; i < 4; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
    axi_write(4'd7, 32'((DEPTH - 2) * 8), 3, 1'b0);
    axi_read(4'd7, 32'((DEPTH - 2) * 8), 3, 0);
    axi_read(4'd6, 32'h0, 1, 0);
    check("wrap_word0", rcap[0], wbuf[2]);
    axi_read(4'd4, 32'(DEPTH * 8), 0, 0);

    // Reset after beat 2 of a 4-beat write
    for (int i = 0; i < 4; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
    bus.awvalid = 1'b1; bus.awid = 4'd3; bus.awaddr = 32'h0; bus.awlen = 8'd3;
    @(negedge clk);
    bus.awvalid = 1'b0;
    idx = 0;
    for (int i = 0; i < 2; i++) begin
      bus.wvalid = 1'b1; bus.wdata = wbuf[i]; bus.wstrb = 8'hFF;
      @(negedge clk);
      ref_mem[idx] = wbuf[i];
      idx++;
    end
    bus.wdata = wbuf[2];
    rst_n = 1'b0;
    #1;
    check("abort_wready", 64'(bus.wready), 64'd0);
    check("abort_bvalid", 64'(bus.bvalid), 64'd0);
    check("abort_awready", 64'(bus.awready), 64'd1);
    bus.wvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    axi_read(4'd1, 32'h0, 3, 0);

    // Random bursts
    for (int t = 0; t < 40; t++) begin
      addr = 32'($urandom_range(0, DEPTH * 8 * 2 - 1));
      len  = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i <= len; i++) begin
          wbuf[i] = {$urandom, $urandom};
          sbuf[i] = 8'($urandom_range(0, 255));
        end
        axi_write(4'($urandom_range(0, 15)), addr, len, 1'b1);
      end else begin
        axi_read(4'($urandom_range(0, 15)), addr, len, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_burst_sram.md
AXI_BURST_SRAM -- requirements
Module: axi_burst_sram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, beat width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 1024, number of DATA_WIDTH words; must be a power of 2.
REQ-003 SHALL have parameter ID_WIDTH, default 4, transaction ID width.
REQ-004 SHALL have port clock  in  1  sole clock; all logic is rising-edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports io_slave_awvalid in 1 and io_slave_awready out 1, the AW handshake.
REQ-007 SHALL have ports io_slave_awid in ID_WIDTH, io_slave_awaddr in 32 and io_slave_awlen in 8 (beats-1).
REQ-008 SHALL have ports io_slave_wvalid in 1 and io_slave_wready out 1, the W handshake.
REQ-009 SHALL have ports io_slave_wdata in DATA_WIDTH, io_slave_wstrb in DATA_WIDTH/8 and io_slave_wlast in 1.
REQ-010 SHALL have ports io_slave_bvalid out 1, io_slave_bready in 1, io_slave_bid out ID_WIDTH and io_slave_bresp out 2.
REQ-011 SHALL have ports io_slave_arvalid in 1, io_slave_arready out 1, io_slave_arid in ID_WIDTH, io_slave_araddr in 32 and io_slave_arlen in 8.
REQ-012 SHALL have ports io_slave_rvalid out 1, io_slave_rready in 1, io_slave_rid out ID_WIDTH, io_slave_rresp out 2, io_slave_rdata out DATA_WIDTH and io_slave_rlast out 1.

Function
REQ-013 SHALL accept INCR bursts of full-width beats only; word index = addr >> log2(DATA_WIDTH/8), taken modulo DEPTH.
REQ-014 SHALL run independent write and read FSMs; both SHALL be able to progress in the same cycle.
REQ-015 Write FSM SHALL have states W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
- W_IDLE: awready=1; an AW handshake latches id, index and len.
- W_DATA: wready=1; each W handshake writes the bytes enabled by wstrb, then index+1 (wraps at DEPTH).
REQ-016 The beat counter SHALL end the burst after awlen+1 beats; wlast SHALL be ignored.
REQ-017 W_RESP SHALL hold bvalid=1 and bid=latched id until bready; W_IDLE SHALL be entered the cycle after the B handshake.
REQ-018 Read FSM SHALL have states R_IDLE -> R_DATA -> R_IDLE.
- R_IDLE: arready=1; an AR handshake latches id, index and len.
- R_DATA: rvalid=1; rdata = word[index], registered so it is stable while rvalid && !rready.
- Each R handshake advances index; rlast=1 on beat arlen+1.
REQ-019 Latency: AW handshake in cycle N -> wready in N+1; last W handshake in N -> bvalid in N+1; AR handshake in N -> first rvalid in N+1.
REQ-020 A read and a write to the same word in the same cycle SHALL return the old data.
REQ-021 Back-to-back: a new AR SHALL be accepted the cycle after the rlast handshake; a new AW SHALL be accepted the cycle after the B handshake.
REQ-022 bresp and rresp SHALL be 2'b00 (OKAY) unless REQ-026 applies.

Reset
REQ-023 On reset low, both FSMs SHALL enter IDLE asynchronously and all counters SHALL clear.
- awready=arready=1; wready=bvalid=rvalid=rlast=0.
- bid, rid, bresp, rresp and rdata SHALL be 0.
- Memory contents SHALL be unchanged.
REQ-024 Reset asserted mid-burst SHALL abort the burst with no response; beats already written SHALL persist.

Configuration
REQ-025 Macro AXI_BURST_SRAM_RANGE_CHECK_EN SHALL select address range checking.
REQ-026 With AXI_BURST_SRAM_RANGE_CHECK_EN defined, a burst whose start address is >= DEPTH*DATA_WIDTH/8 SHALL be answered with SLVERR (2'b10):
- writes are discarded, with normal handshakes;
- reads return rdata=0.
REQ-027 Without AXI_BURST_SRAM_RANGE_CHECK_EN, addresses SHALL wrap modulo DEPTH and the response SHALL always be OKAY.

Structure
REQ-028 Package axi_burst_sram_pkg SHALL hold the W/R state enums, RESP_OKAY/RESP_SLVERR, and the AXI length/ID width constants.
REQ-029 Sub-module axi_burst_sram_mem SHALL contain the storage array: 1 byte-masked write port and 1 synchronous read port.

Verification
REQ-030 After reset, write awaddr=0x0, awlen=3, 4 beats 0x11..0x44 with wstrb all-ones -> bvalid 1 cycle after beat 4, bresp=00, bid=awid.
REQ-031 Read araddr=0x0, arlen=3, rready toggling 1/0 -> rdata 0x11,0x22,0x33,0x44 held stable while stalled, rlast on the 4th beat only.
REQ-032 Write 0xFFFF_FFFF_FFFF_FFFF with wstrb=0x0F over 0x1122334455667788 -> readback 0x11223344FFFFFFFF.
REQ-033 Burst starting at word DEPTH-2 with len=3 -> beats land at words DEPTH-2, DEPTH-1, 0, 1; with RANGE_CHECK_EN, araddr=DEPTH*8 -> rresp=10 and rdata=0.
REQ-034 Reset pulled low after beat 2 of a 4-beat write -> wready=0 and bvalid=0 immediately; words 0-1 updated, words 2-3 unchanged.
